arm_mc_controller: RTL and testbench

ARM_MC_CONTROLLER -- requirements
Module: arm_mc_controller

---
 rtl/arm_pkg.sv | 59 +++++
 rtl/arm_mc_controller_if.sv | 36 +++
 rtl/arm_cond_unit.sv | 59 +++++
 rtl/arm_mc_controller.sv | 162 ++++++++++++++++
 tb/tb_arm_mc_controller.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM multicycle controller.
// States, ALU codes, opcode classes and condition codes.
package arm_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Data-processing cmd field to ALU operation; unknown cmds add.
    function automatic logic [1:0] alu_decode(logic [3:0] cmd);
        logic [1:0] r;
        r = ALU_ADD;
        case (cmd)
            4'b0100: r = ALU_ADD;
            4'b0010: r = ALU_SUB;
            4'b0000: r = ALU_AND;
            4'b1100: r = ALU_ORR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_mc_controller_if.sv
// Controller <-> datapath/memory bundle.
// master = controller side, slave = datapath side.
interface arm_mc_controller_if;
    import arm_pkg::*;

    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic        AdrSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  state_o;

    modport master (
        input  Instr, ALUFlags, mem_ready,
        output PCWrite, IRWrite, RegWrite, MemWrite,
        output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output ImmSrc, RegSrc, ALUControl, state_o
    );

    modport slave (
        output Instr, ALUFlags, mem_ready,
        input  PCWrite, IRWrite, RegWrite, MemWrite,
        input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  ImmSrc, RegSrc, ALUControl, state_o
    );

endinterface

// File: rtl/arm_cond_unit.sv
// Condition evaluation against the stored NZCV flags,
// plus the flag register itself.
module arm_cond_unit
    import arm_pkg::*;
#(
    parameter int NUM_COND = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       upd_nz,
    input  logic       upd_cv,
    output logic       condex,
    output logic [3:0] flags
);

    localparam logic [4:0] NC = 5'(NUM_COND);

    logic n, z, c, v;
    logic ok;

    assign {n, z, c, v} = flags;

    // Decode the condition; codes beyond NUM_COND never pass.
    always_comb begin
        ok = 1'b0;
        case (cond)
            COND_EQ: ok = z;
            COND_NE: ok = !z;
            COND_CS: ok = c;
            COND_CC: ok = !c;
            COND_MI: ok = n;
            COND_PL: ok = !n;
            COND_VS: ok = v;
            COND_VC: ok = !v;
            COND_HI: ok = c && !z;
            COND_LS: ok = !c || z;
            COND_GE: ok = (n == v);
            COND_LT: ok = (n != v);
            COND_GT: ok = !z && (n == v);
            COND_LE: ok = z || (n != v);
            COND_AL: ok = 1'b1;
            COND_NV: ok = 1'b0;
        endcase
        condex = ok && ({1'b0, cond} < NC);
    end

    // NZ and CV halves update independently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= 4'b0000;
        end else begin
            if (upd_nz) flags[3:2] <= alu_flags[3:2];
            if (upd_cv) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM with instruction decoders.
// Outputs are forced to zero while reset is held low.
module arm_mc_controller
    import arm_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int NUM_COND      = 16
) (
    input  logic clk,
    input  logic reset,
    arm_mc_controller_if.master bus
);

    localparam bit HS = (MEM_HANDSHAKE != 0);

    state_e     state;
    state_e     state_nx;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       condex;
    logic       rdy;
    logic       pc_dest;
    logic       exec;
    logic       upd_nz;
    logic       upd_cv;
    logic [1:0] alu_dp;
    logic [3:0] flags;
    logic       unused_rn;

    logic       pcw, irw, regw, memw;
    logic       adrsrc, srca;
    logic [1:0] srcb, ressrc, aluctl;

    assign cond      = bus.Instr[19:16];
    assign op        = bus.Instr[15:14];
    assign funct     = bus.Instr[13:8];
    assign rd        = bus.Instr[3:0];
    assign unused_rn = ^{bus.Instr[7:4], flags};

    assign rdy     = HS ? bus.mem_ready : 1'b1;
    assign pc_dest = (rd == 4'hF);
    assign alu_dp  = alu_decode(funct[4:1]);
    assign exec    = (state == EXECR) || (state == EXECI);
    assign upd_nz  = exec && funct[0] && condex;
    assign upd_cv  = upd_nz &&
                     ((alu_dp == ALU_ADD) || (alu_dp == ALU_SUB));

    arm_cond_unit #(
        .NUM_COND (NUM_COND)
    ) u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (cond),
        .alu_flags (bus.ALUFlags),
        .upd_nz    (upd_nz),
        .upd_cv    (upd_cv),
        .condex    (condex),
        .flags     (flags)
    );

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nx;
    end

    // Next state and per-state strobes/selects.
    always_comb begin
        state_nx = state;
        pcw      = 1'b0;
        irw      = 1'b0;
        regw     = 1'b0;
        memw     = 1'b0;
        adrsrc   = 1'b0;
        srca     = 1'b0;
        srcb     = 2'b00;
        ressrc   = 2'b00;
        aluctl   = ALU_ADD;
        unique case (state)
            FETCH: begin
                srca   = 1'b1;
                srcb   = 2'b10;
                ressrc = 2'b10;
                if (rdy) begin
                    irw      = 1'b1;
                    pcw      = 1'b1;
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                srca   = 1'b1;
                srcb   = 2'b10;
                ressrc = 2'b10;
                unique case (op)
                    OP_MEM: state_nx = MEMADR;
                    OP_DP:  state_nx = funct[5] ? EXECI : EXECR;
                    OP_BR:  state_nx = BRANCH;
                    OP_NOP: state_nx = FETCH;
                endcase
            end
            MEMADR: begin
                srcb     = 2'b01;
                state_nx = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adrsrc = 1'b1;
                if (rdy) state_nx = MEMWB;
            end
            MEMWB: begin
                ressrc   = 2'b01;
                regw     = condex;
                pcw      = condex && pc_dest;
                state_nx = FETCH;
            end
            MEMWR: begin
                adrsrc = 1'b1;
                memw   = condex;
                if (rdy) state_nx = FETCH;
            end
            EXECR: begin
                srcb     = 2'b00;
                aluctl   = alu_dp;
                state_nx = ALUWB;
            end
            EXECI: begin
                srcb     = 2'b01;
                aluctl   = alu_dp;
                state_nx = ALUWB;
            end
            ALUWB: begin
                ressrc   = 2'b00;
                regw     = condex;
                pcw      = condex && pc_dest;
                state_nx = FETCH;
            end
            BRANCH: begin
                srcb     = 2'b01;
                ressrc   = 2'b10;
                pcw      = condex;
                state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    assign bus.PCWrite    = reset && pcw;
    assign bus.IRWrite    = reset && irw;
    assign bus.RegWrite   = reset && regw;
    assign bus.MemWrite   = reset && memw;
    assign bus.AdrSrc     = reset && adrsrc;
    assign bus.ALUSrcA    = reset && srca;
    assign bus.ALUSrcB    = reset ? srcb   : 2'b00;
    assign bus.ResultSrc  = reset ? ressrc : 2'b00;
    assign bus.ALUControl = reset ? aluctl : 2'b00;
    assign bus.ImmSrc     = reset ? op     : 2'b00;
    assign bus.RegSrc     = reset ?
                            {op == OP_MEM, op == OP_BR} : 2'b00;
    assign bus.state_o    = state;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller.
// Instruction-level reference model builds per-cycle expectations.
module tb_arm_mc_controller;
    import arm_pkg::*;

    typedef struct {
        state_e      st;
        bit          rdy;
        logic [15:0] v;
        logic [15:0] m;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_mc_controller_if bus ();
    arm_mc_controller_if bus0 ();

    arm_mc_controller #(
        .MEM_HANDSHAKE (1),
        .NUM_COND      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    arm_mc_controller #(
        .MEM_HANDSHAKE (0),
        .NUM_COND      (16)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] mflags;
    exp_t q[$];

    function automatic logic [15:0] obs();
        return {bus.PCWrite, bus.IRWrite, bus.RegWrite,
                bus.MemWrite, bus.AdrSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ResultSrc, bus.ALUControl,
                bus.ImmSrc, bus.RegSrc};
    endfunction

    function automatic bit cond_ok(logic [3:0] fl, logic [3:0] c);
        bit n, z, cf, v;
        n = fl[3]; z = fl[2]; cf = fl[1]; v = fl[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic b1(int x);
        return (x < 0) ? 1'b0 : x[0];
    endfunction
    function automatic logic [1:0] b2(int x);
        return (x < 0) ? 2'b00 : x[1:0];
    endfunction
    function automatic logic m1(int x);
        return (x >= 0);
    endfunction
    function automatic logic [1:0] m2(int x);
        return (x >= 0) ? 2'b11 : 2'b00;
    endfunction

    // -1 in a select field means the value is not defined there.
    function automatic exp_t mk(state_e st, bit rdy, bit pcw,
                                bit irw, bit regw, bit memw,
                                int adr, int srca, int srcb,
                                int res, logic [1:0] aluc,
                                logic [1:0] op);
        exp_t e;
        e.st  = st;
        e.rdy = rdy;
        e.v = {pcw, irw, regw, memw, b1(adr), b1(srca),
               b2(srcb), b2(res), aluc, op,
               op == 2'b01, op == 2'b10};
        e.m = {4'hF, m1(adr), m1(srca), m2(srcb), m2(res),
               6'h3F};
        return e;
    endfunction

    task automatic build(input logic [19:0] ins,
                         input logic [3:0] af,
                         input int wf, input int wm);
        logic [3:0] c;
        logic [1:0] op;
        logic [5:0] f;
        logic [1:0] ac;
        bit ce, pd, cv;
        c  = ins[19:16];
        op = ins[15:14];
        f  = ins[13:8];
        pd = (ins[3:0] == 4'hF);
        q.delete();
        for (int i = 0; i < wf; i++)
            q.push_back(mk(FETCH, 0, 0, 0, 0, 0,
                           0, 1, 2, 2, 2'b00, op));
        q.push_back(mk(FETCH, 1, 1, 1, 0, 0,
                       0, 1, 2, 2, 2'b00, op));
        q.push_back(mk(DECODE, 1'($urandom), 0, 0, 0, 0,
                       -1, 1, 2, 2, 2'b00, op));
        ce = cond_ok(mflags, c);
        case (op)
            2'b00: begin
                case (f[4:1])
                    4'b0010: ac = 2'b01;
                    4'b0000: ac = 2'b10;
                    4'b1100: ac = 2'b11;
                    default: ac = 2'b00;
                endcase
                cv = (f[4:1] != 4'b0000) && (f[4:1] != 4'b1100);
                q.push_back(mk(f[5] ? EXECI : EXECR, 1'($urandom),
                               0, 0, 0, 0, -1, 0,
                               f[5] ? 1 : 0, -1, ac, op));
                if (f[0] && ce) begin
                    mflags[3:2] = af[3:2];
                    if (cv) mflags[1:0] = af[1:0];
                end
                ce = cond_ok(mflags, c);
                q.push_back(mk(ALUWB, 1'($urandom), ce && pd, 0,
                               ce, 0, -1, -1, -1, 0, 2'b00, op));
            end
            2'b01: begin
                q.push_back(mk(MEMADR, 1'($urandom), 0, 0, 0, 0,
                               -1, 0, 1, -1, 2'b00, op));
                if (f[0]) begin
                    for (int i = 0; i < wm; i++)
                        q.push_back(mk(MEMRD, 0, 0, 0, 0, 0,
                                       1, -1, -1, -1, 2'b00, op));
                    q.push_back(mk(MEMRD, 1, 0, 0, 0, 0,
                                   1, -1, -1, -1, 2'b00, op));
                    q.push_back(mk(MEMWB, 1'($urandom), ce && pd,
                                   0, ce, 0, -1, -1, -1, 1,
                                   2'b00, op));
                end else begin
                    for (int i = 0; i < wm; i++)
                        q.push_back(mk(MEMWR, 0, 0, 0, 0, ce,
                                       1, -1, -1, -1, 2'b00, op));
                    q.push_back(mk(MEMWR, 1, 0, 0, 0, ce,
                                   1, -1, -1, -1, 2'b00, op));
                end
            end
            2'b10: begin
                q.push_back(mk(BRANCH, 1'($urandom), ce, 0, 0, 0,
                               -1, 0, 1, 2, 2'b00, op));
            end
            default: ;
        endcase
    endtask

    task automatic run_q(input string tag, input int lim);
        int n;
        n = (lim < q.size()) ? lim : q.size();
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = q[i].rdy;
            @(negedge clk);
            checks++;
            assert (bus.state_o === 4'(q[i].st) &&
                    (obs() & q[i].m) === (q[i].v & q[i].m))
            else begin
                errors++;
                $error("FAIL %s cyc%0d state=%0d out=%h expect state=%0d out=%h mask=%h",
                       tag, i, bus.state_o, obs(), q[i].st,
                       q[i].v, q[i].m);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string tag,
                            input logic [19:0] ins,
                            input logic [3:0] af,
                            input int wf, input int wm,
                            input int lim);
        build(ins, af, wf, wm);
        bus.Instr    = ins;
        bus.ALUFlags = af;
        run_q(tag, lim);
    endtask

    task automatic chk_flags(input string tag,
                             input logic [3:0] exp);
        checks++;
        assert (dut.u_cond.flags === exp)
        else begin
            errors++;
            $error("FAIL %s flags=%b expect=%b", tag,
                   dut.u_cond.flags, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        checks++;
        assert (obs() === 16'h0000 &&
                bus.state_o === 4'(FETCH))
        else begin
            errors++;
            $error("FAIL %s out=%h state=%0d expect out=0000 state=0",
                   tag, obs(), bus.state_o);
        end
    endtask

    localparam logic [19:0] ADDS  = 20'hE0921;
    localparam logic [19:0] LDR   = {4'hE, 2'b01, 6'b011001, 8'h02};
    localparam logic [19:0] STR   = {4'hE, 2'b01, 6'b011000, 8'h03};
    localparam logic [19:0] SUBS  = {4'hE, 2'b00, 6'b000101, 8'h12};
    localparam logic [19:0] ANDS  = {4'hE, 2'b00, 6'b000001, 8'h12};
    localparam logic [19:0] BEQ   = {4'h0, 2'b10, 6'b100000, 8'h00};

    initial begin
        state_e es[5];
        bit     ep[5];
        bit     em[5];
        bit     found;
        int     mw_cnt;

        reset         = 1'b0;
        mflags        = 4'h0;
        bus.Instr     = ADDS;
        bus.ALUFlags  = 4'hF;
        bus.mem_ready = 1'b1;
        bus0.Instr    = {4'hE, 2'b11, 14'h0};
        bus0.ALUFlags = 4'h0;
        bus0.mem_ready = 1'b0;

        #3;
        chk_rst("rst_init");
        repeat (2) @(posedge clk);
        #1;
        chk_rst("rst_hold");
        chk_flags("rst_flags", 4'b0000);
        reset = 1'b1;

        do_instr("adds", ADDS, 4'b0110, 0, 0, 1000);
        chk_flags("adds_flags", 4'b0110);

        do_instr("ldr_wait3", LDR, 4'h0, 0, 3, 1000);

        do_instr("subs_z1", SUBS, 4'b0100, 1, 0, 1000);
        chk_flags("subs_z1_flags", 4'b0100);
        do_instr("beq_taken", BEQ, 4'h0, 0, 0, 1000);

        do_instr("str_rst", STR, 4'h0, 0, 5, 4);
        bus.mem_ready = 1'b0;
        #2;
        checks++;
        assert (bus.MemWrite === 1'b1 &&
                bus.state_o === 4'(MEMWR))
        else begin
            errors++;
            $error("FAIL str_pre_rst memw=%b state=%0d expect 1/%0d",
                   bus.MemWrite, bus.state_o, MEMWR);
        end
        reset = 1'b0;
        mflags = 4'h0;
        #1;
        chk_rst("rst_async");
        chk_flags("rst_async_flags", 4'b0000);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        #1;
        chk_rst("rst_low_ready");
        reset = 1'b1;

        do_instr("ands", ANDS, 4'b1011, 0, 0, 1000);
        chk_flags("ands_flags", 4'b1000);

        do_instr("subs_z0", SUBS, 4'b0000, 0, 0, 1000);
        do_instr("beq_not", BEQ, 4'h0, 2, 0, 1000);

        for (int k = 0; k < 40; k++) begin
            logic [19:0] ins;
            ins = 20'($urandom);
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'hF;
            do_instr($sformatf("rnd%0d", k), ins,
                     4'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1000);
            chk_flags($sformatf("rnd%0d_flags", k), mflags);
        end

        es = '{FETCH, DECODE, MEMADR, MEMWR, FETCH};
        ep = '{1, 0, 0, 0, 1};
        em = '{0, 0, 0, 1, 0};
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            if (bus0.state_o === 4'(FETCH)) found = 1;
        end
        checks++;
        assert (found)
        else begin
            errors++;
            $error("FAIL hs0_align state=%0d expect %0d",
                   bus0.state_o, FETCH);
        end
        bus0.Instr = STR;
        mw_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            if (bus0.MemWrite === 1'b1) mw_cnt++;
            checks++;
            assert (bus0.state_o === 4'(es[i]) &&
                    bus0.PCWrite === ep[i] &&
                    bus0.MemWrite === em[i])
            else begin
                errors++;
                $error("FAIL hs0_str cyc%0d state=%0d pcw=%b memw=%b expect %0d/%b/%b",
                       i, bus0.state_o, bus0.PCWrite,
                       bus0.MemWrite, es[i], ep[i], em[i]);
            end
        end
        checks++;
        assert (mw_cnt === 1)
        else begin
            errors++;
            $error("FAIL hs0_memw_count got=%0d expect=1", mw_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
